// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: next-PC selection, fetch request handshake, pending redirect buffer, halt/resume.
// Optional vectored trap targets are enabled with COTM32_PC_VECTORED_TRAP_EN.
module pc_seq_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BOOT_DELAY   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_addr,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_vec,
`ifdef COTM32_PC_VECTORED_TRAP_EN
  input  logic            i_trap_vectored,
  input  logic [4:0]      i_trap_cause,
`endif
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_halt_req,
  input  logic            i_resume_req,
  input  logic            i_fetch_ready,
  output logic            o_fetch_valid,
  output logic [XLEN-1:0] o_fetch_addr,
  output logic            o_pc_we,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_halted,
  output logic            o_t_inst_addr_misaligned
);

  localparam int unsigned CNT_W = (BOOT_DELAY < 2) ? 1 : $clog2(BOOT_DELAY + 1);

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HALTED} state_e;
  // Encoding doubles as priority: larger value wins.
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_REDIR = 2'd1, SRC_MRET = 2'd2, SRC_TRAP = 2'd3} src_e;

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_boot_cnt, w_boot_cnt_nxt;
  logic [XLEN-1:0]   r_pc;
  logic              r_fetch_valid, w_fetch_valid_nxt;
  logic              r_halted, w_halted_nxt;
  logic              r_misaligned, w_misaligned_nxt;
  src_e              r_pend_src, w_pend_src_nxt;
  logic [XLEN-1:0]   r_pend_addr, w_pend_addr_nxt;

  logic [XLEN-1:0]   w_trap_tgt;
  src_e              w_raw_src, w_ev_src, w_win_src;
  logic [XLEN-1:0]   w_raw_addr, w_win_addr;
  logic              w_bad, w_ev_wins, w_hs, w_apply, w_pc_we;
  logic [XLEN-1:0]   w_next_pc;

  // Trap target: aligned base, optionally offset by cause in vectored mode
`ifdef COTM32_PC_VECTORED_TRAP_EN
  always_comb begin
    w_trap_tgt = i_trap_vec & ~XLEN'(3);
    if (i_trap_vectored && (i_trap_vec[1:0] == 2'b01)) begin
      w_trap_tgt = w_trap_tgt + XLEN'({i_trap_cause, 2'b00});
    end
  end
`else
  assign w_trap_tgt = i_trap_vec & ~XLEN'(3);
`endif

  // Incoming event arbitration, alignment check and merge with the pending entry
  always_comb begin
    w_raw_src  = SRC_NONE;
    w_raw_addr = '0;
    if (i_trap_valid && (r_state != ST_BOOT)) begin
      w_raw_src  = SRC_TRAP;
      w_raw_addr = w_trap_tgt;
    end else if (i_mret && (r_state == ST_FETCH)) begin
      w_raw_src  = SRC_MRET;
      w_raw_addr = i_mepc;
    end else if (i_redirect_valid && (r_state == ST_FETCH)) begin
      w_raw_src  = SRC_REDIR;
      w_raw_addr = i_redirect_addr;
    end
    w_bad      = ((w_raw_src == SRC_MRET) || (w_raw_src == SRC_REDIR)) && (w_raw_addr[1:0] != 2'b00);
    w_ev_src   = w_bad ? SRC_NONE : w_raw_src;
    w_ev_wins  = (w_ev_src != SRC_NONE) && (w_ev_src >= r_pend_src);
    w_win_src  = w_ev_wins ? w_ev_src : r_pend_src;
    w_win_addr = w_ev_wins ? w_raw_addr : r_pend_addr;
    w_hs       = r_fetch_valid && i_fetch_ready;
    // PC may move when nothing is in flight, on acceptance, or on leaving halt
    w_apply    = ((r_state == ST_FETCH) && (!r_fetch_valid || i_fetch_ready)) ||
                 ((r_state == ST_HALTED) && i_resume_req);
    w_pc_we    = w_hs || (w_apply && (w_win_src != SRC_NONE));
    w_next_pc  = (w_win_src != SRC_NONE) ? w_win_addr : r_pc + XLEN'(4);
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_boot_cnt_nxt    = r_boot_cnt;
    w_fetch_valid_nxt = r_fetch_valid;
    w_halted_nxt      = r_halted;
    w_misaligned_nxt  = 1'b0;
    w_pend_src_nxt    = r_pend_src;
    w_pend_addr_nxt   = r_pend_addr;

    if (w_apply) begin
      w_pend_src_nxt = SRC_NONE;
    end else if (w_ev_wins) begin
      w_pend_src_nxt  = w_ev_src;
      w_pend_addr_nxt = w_raw_addr;
    end

    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt <= CNT_W'(1)) begin
          w_state_nxt    = ST_FETCH;
          w_boot_cnt_nxt = '0;
        end else begin
          w_boot_cnt_nxt = r_boot_cnt - CNT_W'(1);
        end
      end
      ST_FETCH: begin
        w_misaligned_nxt = w_bad;
        if (!r_fetch_valid || i_fetch_ready) begin
          if (i_halt_req) begin
            w_state_nxt       = ST_HALTED;
            w_fetch_valid_nxt = 1'b0;
            w_halted_nxt      = 1'b1;
          end else begin
            w_fetch_valid_nxt = !i_stall;
          end
        end
      end
      ST_HALTED: begin
        if (i_resume_req) begin
          w_state_nxt  = ST_FETCH;
          w_halted_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_BOOT;
      r_boot_cnt    <= CNT_W'(BOOT_DELAY);
      r_pc          <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_misaligned  <= 1'b0;
      r_pend_src    <= SRC_NONE;
      r_pend_addr   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_boot_cnt    <= w_boot_cnt_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_halted      <= w_halted_nxt;
      r_misaligned  <= w_misaligned_nxt;
      r_pend_src    <= w_pend_src_nxt;
      r_pend_addr   <= w_pend_addr_nxt;
      if (w_pc_we) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign o_fetch_valid            = r_fetch_valid;
  assign o_fetch_addr             = r_pc;
  assign o_pc_we                  = w_pc_we;
  assign o_next_pc                = w_next_pc;
  assign o_halted                 = r_halted;
  assign o_t_inst_addr_misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: expected fetch addresses are queued as stimulus is driven
// and popped at every fetch handshake; directed checks cover redirect, trap, mret, halt and wrap.
module tb_pc_seq_ctrl;
  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic        trap_vectored;
  logic [4:0]  trap_cause;
  logic        mret;
  logic [31:0] mepc;
  logic        halt_req;
  logic        resume_req;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        pc_we;
  logic [31:0] next_pc;
  logic        halted;
  logic        misaligned;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  pc_seq_ctrl #(.XLEN(XLEN), .RESET_VECTOR(RV), .BOOT_DELAY(4)) u_dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_stall                  (stall),
    .i_redirect_valid         (redirect_valid),
    .i_redirect_addr          (redirect_addr),
    .i_trap_valid             (trap_valid),
    .i_trap_vec               (trap_vec),
`ifdef COTM32_PC_VECTORED_TRAP_EN
    .i_trap_vectored          (trap_vectored),
    .i_trap_cause             (trap_cause),
`endif
    .i_mret                   (mret),
    .i_mepc                   (mepc),
    .i_halt_req               (halt_req),
    .i_resume_req             (resume_req),
    .i_fetch_ready            (fetch_ready),
    .o_fetch_valid            (fetch_valid),
    .o_fetch_addr             (fetch_addr),
    .o_pc_we                  (pc_we),
    .o_next_pc                (next_pc),
    .o_halted                 (halted),
    .o_t_inst_addr_misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From idle with stall high: issue one fetch at exp_addr and let it be accepted
  task automatic issue_one(input logic [31:0] exp_addr);
    exp_q.push_back(exp_addr);
    stall       = 1'b0;
    fetch_ready = 1'b1;
    tick();
    stall = 1'b1;
    tick();
    check_eq("issue_idle", 32'(fetch_valid), 32'd0);
  endtask

  // Scoreboard: every accepted fetch must match the next queued address
  always @(negedge clk) begin
    if (rst_n && fetch_valid && fetch_ready) begin
      check_eq("hs_pc_we", 32'(pc_we), 32'd1);
      if (exp_q.size() == 0) check_eq("hs_queue", 32'(exp_q.size()), 32'd1);
      else                   check_eq("hs_addr", fetch_addr, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    trap_valid = 1'b0; trap_vec = '0; trap_vectored = 1'b0; trap_cause = '0;
    mret = 1'b0; mepc = '0; halt_req = 1'b0; resume_req = 1'b0; fetch_ready = 1'b0;

    repeat (3) tick();
    check_eq("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check_eq("rst_pc_we", 32'(pc_we), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_misaligned", 32'(misaligned), 32'd0);
    check_eq("rst_fetch_addr", fetch_addr, RV);

    // Boot sequence and three back-to-back fetches
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0004);
    exp_q.push_back(32'h8000_0008);
    fetch_ready = 1'b1;
    rst_n       = 1'b1;
    repeat (4) tick();
    check_eq("boot_no_fetch", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("first_fetch_valid", 32'(fetch_valid), 32'd1);
    check_eq("first_fetch_addr", fetch_addr, RV);
    tick();
    tick();
    stall = 1'b1;
    tick();
    check_eq("boot_run_idle", 32'(fetch_valid), 32'd0);
    check_eq("boot_run_pc", fetch_addr, 32'h8000_000C);
    check_eq("boot_run_q", 32'(exp_q.size()), 32'd0);

    // Redirect buffered while the request is held off
    stall = 1'b0; fetch_ready = 1'b0;
    tick();
    check_eq("buf_fetch_valid", 32'(fetch_valid), 32'd1);
    redirect_valid = 1'b1; redirect_addr = 32'h100;
    #1;
    check_eq("buf_no_we", 32'(pc_we), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check_eq("buf_hold1", fetch_addr, 32'h8000_000C);
    tick();
    check_eq("buf_hold2", fetch_addr, 32'h8000_000C);
    check_eq("buf_hold_valid", 32'(fetch_valid), 32'd1);
    exp_q.push_back(32'h8000_000C);
    fetch_ready = 1'b1; stall = 1'b1;
    #1;
    check_eq("buf_hs_we", 32'(pc_we), 32'd1);
    check_eq("buf_hs_next", next_pc, 32'h100);
    tick();
    check_eq("buf_pc", fetch_addr, 32'h100);
    issue_one(32'h100);

    // Trap beats a same-cycle redirect; low target bits forced to zero
    redirect_valid = 1'b1; redirect_addr = 32'h200;
    trap_valid = 1'b1; trap_vec = 32'h301;
    #1;
    check_eq("trap_we", 32'(pc_we), 32'd1);
    check_eq("trap_next", next_pc, 32'h300);
    tick();
    redirect_valid = 1'b0; trap_valid = 1'b0;
    issue_one(32'h300);

    // Misaligned mret is dropped with a one-cycle pulse
    mret = 1'b1; mepc = 32'h402;
    #1;
    check_eq("mis_no_we", 32'(pc_we), 32'd0);
    tick();
    mret = 1'b0;
    check_eq("mis_pulse", 32'(misaligned), 32'd1);
    check_eq("mis_pc", fetch_addr, 32'h304);
    tick();
    check_eq("mis_pulse_end", 32'(misaligned), 32'd0);
    issue_one(32'h304);

    // Resume outside HALTED has no effect
    resume_req = 1'b1;
    #1;
    check_eq("resume_ign_we", 32'(pc_we), 32'd0);
    tick();
    resume_req = 1'b0;
    check_eq("resume_ign_halted", 32'(halted), 32'd0);

    // Halt waits for the outstanding handshake; trap while halted applies on resume
    stall = 1'b0; fetch_ready = 1'b0;
    tick();
    halt_req = 1'b1;
    tick();
    check_eq("halt_wait", 32'(halted), 32'd0);
    check_eq("halt_wait_fv", 32'(fetch_valid), 32'd1);
    exp_q.push_back(32'h308);
    fetch_ready = 1'b1;
    tick();
    check_eq("halt_entered", 32'(halted), 32'd1);
    check_eq("halt_fv", 32'(fetch_valid), 32'd0);
    halt_req = 1'b0; stall = 1'b1; fetch_ready = 1'b0;
    trap_valid = 1'b1; trap_vec = 32'h500;
    #1;
    check_eq("halt_trap_no_we", 32'(pc_we), 32'd0);
    tick();
    trap_valid = 1'b0;
    tick();
    check_eq("halt_still", 32'(halted), 32'd1);
    check_eq("halt_pc", fetch_addr, 32'h30C);
    resume_req = 1'b1;
    #1;
    check_eq("resume_we", 32'(pc_we), 32'd1);
    check_eq("resume_next", next_pc, 32'h500);
    tick();
    resume_req = 1'b0;
    check_eq("resume_halted", 32'(halted), 32'd0);
    check_eq("resume_pc", fetch_addr, 32'h500);
    issue_one(32'h500);

    // Trap target mode
    trap_valid = 1'b1; trap_vec = 32'h1001; trap_vectored = 1'b1; trap_cause = 5'd3;
    #1;
    check_eq("vec_we", 32'(pc_we), 32'd1);
`ifdef COTM32_PC_VECTORED_TRAP_EN
    check_eq("vec_next", next_pc, 32'h100C);
    tick();
    trap_valid = 1'b0; trap_vectored = 1'b0;
    issue_one(32'h100C);
`else
    check_eq("direct_next", next_pc, 32'h1000);
    tick();
    trap_valid = 1'b0; trap_vectored = 1'b0;
    issue_one(32'h1000);
`endif

    // Sequential wrap at the top of the address space
    redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    #1;
    check_eq("wrap_redir_we", 32'(pc_we), 32'd1);
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    stall = 1'b0; fetch_ready = 1'b1;
    tick();
    check_eq("wrap_next", next_pc, 32'h0);
    tick();
    stall = 1'b1;
    tick();
    check_eq("wrap_pc", fetch_addr, 32'h4);

    // Pending mret is not displaced by a later, lower-priority redirect
    stall = 1'b0; fetch_ready = 1'b0;
    tick();
    exp_q.push_back(32'h4);
    mret = 1'b1; mepc = 32'h600;
    tick();
    mret = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 32'h700;
    tick();
    redirect_valid = 1'b0;
    fetch_ready = 1'b1; stall = 1'b1;
    #1;
    check_eq("prio_we", 32'(pc_we), 32'd1);
    check_eq("prio_next", next_pc, 32'h600);
    tick();
    issue_one(32'h600);

    // Asynchronous reset abandons an outstanding request
    stall = 1'b0; fetch_ready = 1'b0;
    tick();
    check_eq("arst_pre_fv", 32'(fetch_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_fv", 32'(fetch_valid), 32'd0);
    check_eq("arst_pc", fetch_addr, RV);
    check_eq("final_q", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
